input_port_fifo: RTL and testbench

//  Parametrised CPU input port. Captures the external input unit word on a strobe

---
 rtl/io_port_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/input_port_fifo.sv | 79 +++++++
 tb/tb_input_port_fifo.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/io_port_pkg.sv
`default_nettype none
// ============================================================================
// Module : io_port_pkg
// Brief  : Shared constants for the CPU I/O port blocks: default data width
//          and the status-bit layout used when the port status is read back.
// Rev    : 1.0  initial release
// ============================================================================
package io_port_pkg;

  // Default datapath / input-unit width
  localparam int DATA_W = 32;

  // Bit positions inside a port status word
  localparam int STAT_VALID = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_W     = 3;

  // Status word view of the port flags
  typedef struct packed {
    logic ovf;
    logic full;
    logic valid;
  } port_status_t;

endpackage : io_port_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO with first-word-fall-through head output.
//          Pops of an empty FIFO are ignored; a push into a full FIFO is only
//          accepted when a pop makes room in the same cycle.
// Rev    : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  // Qualify requests against occupancy; a full FIFO accepts a push only
  // alongside a pop, which is always legal because full implies non-empty.
  always_comb begin
    w_do_pop  = pop & ~empty;
    w_do_push = push & (~full | w_do_pop);
  end

  // Storage array; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking; pointers wrap mod DEPTH, count never wraps
  always_ff @(posedge clk) begin
    if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);

endmodule : sync_fifo
`default_nettype wire

// File: rtl/input_port_fifo.sv
`default_nettype none
// ============================================================================
// Module : input_port_fifo
// Brief  : CPU input port. Captures the input-unit word on a strobe (edge or
//          level qualified) into a small FIFO and presents the head word to
//          the datapath bus mux, zero when empty. Tracks a sticky overflow
//          flag for dropped captures.
// Rev    : 1.0  initial release
// ============================================================================
module input_port_fifo
  import io_port_pkg::*;
#(
  parameter int WIDTH     = DATA_W,
  parameter int DEPTH     = 4,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [WIDTH-1:0]           input_unit,
  input  logic                       strobe,
  input  logic                       rd_en,
  input  logic                       ovf_clr,
  output logic [WIDTH-1:0]           bus_mux_in_port_in,
  output logic                       data_valid,
  output logic                       full,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  logic             r_strobe_q;
  logic             r_overflow;
  logic             w_push_req;
  logic             w_drop;
  logic             w_empty;
  logic [WIDTH-1:0] w_head;

  // Strobe qualification and drop detection; a pop alongside a full push
  // frees a slot, so only an unaccompanied full push is dropped.
  always_comb begin
    w_push_req = EDGE_MODE ? (strobe & ~r_strobe_q) : strobe;
    w_drop     = w_push_req & full & ~rd_en;
  end

  // Strobe history for edge detection; cleared so a strobe held across
  // reset release counts as one fresh request.
  always_ff @(posedge clk) begin
    if (clr) r_strobe_q <= 1'b0;
    else     r_strobe_q <= strobe;
  end

  // Sticky overflow: a new drop wins over a same-cycle clear request
  always_ff @(posedge clk) begin
    if (clr)          r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
    else if (ovf_clr) r_overflow <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (w_push_req),
    .pop   (rd_en),
    .wdata (input_unit),
    .head  (w_head),
    .count (count),
    .full  (full),
    .empty (w_empty)
  );

  assign data_valid         = ~w_empty;
  assign overflow           = r_overflow;
  // Never expose stale storage on the shared bus
  assign bus_mux_in_port_in = w_empty ? '0 : w_head;

endmodule : input_port_fifo
`default_nettype wire

// File: tb/tb_input_port_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_input_port_fifo
// Brief  : Directed self-checking bench; one edge-mode and one level-mode
//          instance of the input port, DEPTH=4, WIDTH=32.
// Rev    : 1.0  initial release
// ============================================================================
module tb_input_port_fifo;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Edge-mode instance signals
  logic        e_clr = 1'b1, e_strobe = 1'b0, e_rd = 1'b0, e_ovfclr = 1'b0;
  logic [31:0] e_in = '0, e_bus;
  logic        e_valid, e_full, e_ovf;
  logic [2:0]  e_count;

  // Level-mode instance signals
  logic        l_clr = 1'b1, l_strobe = 1'b0, l_rd = 1'b0, l_ovfclr = 1'b0;
  logic [31:0] l_in = '0, l_bus;
  logic        l_valid, l_full, l_ovf;
  logic [2:0]  l_count;

  int checks = 0;
  int errors = 0;

  input_port_fifo #(.WIDTH(32), .DEPTH(4), .EDGE_MODE(1'b1)) u_edge (
    .clk(clk), .clr(e_clr), .input_unit(e_in), .strobe(e_strobe),
    .rd_en(e_rd), .ovf_clr(e_ovfclr), .bus_mux_in_port_in(e_bus),
    .data_valid(e_valid), .full(e_full), .overflow(e_ovf), .count(e_count)
  );

  input_port_fifo #(.WIDTH(32), .DEPTH(4), .EDGE_MODE(1'b0)) u_lvl (
    .clk(clk), .clr(l_clr), .input_unit(l_in), .strobe(l_strobe),
    .rd_en(l_rd), .ovf_clr(l_ovfclr), .bus_mux_in_port_in(l_bus),
    .data_valid(l_valid), .full(l_full), .overflow(l_ovf), .count(l_count)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_edge(input logic [31:0] d);
    e_in = d; e_strobe = 1'b1; tick();
    e_strobe = 1'b0; tick();
  endtask

  task automatic pop_edge();
    e_rd = 1'b1; tick();
    e_rd = 1'b0;
  endtask

  task automatic test_reset();
    e_clr = 1'b1; l_clr = 1'b1;
    e_strobe = 1'b1; l_strobe = 1'b1; tick();
    e_strobe = 1'b0; l_strobe = 1'b0; tick();
    checks++; if (e_count !== 3'd0 || l_count !== 3'd0) begin errors++;
      $display("FAIL reset_count edge=%0d lvl=%0d want 0", e_count, l_count); end
    checks++; if (e_valid !== 1'b0 || l_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid edge=%b lvl=%b want 0", e_valid, l_valid); end
    checks++; if (e_bus !== 32'h0 || l_bus !== 32'h0) begin errors++;
      $display("FAIL reset_bus edge=%h lvl=%h want 0", e_bus, l_bus); end
    checks++; if (e_ovf !== 1'b0 || l_ovf !== 1'b0 || e_full !== 1'b0) begin errors++;
      $display("FAIL reset_flags ovf=%b/%b full=%b want 0", e_ovf, l_ovf, e_full); end
    e_clr = 1'b0; l_clr = 1'b0; tick();
  endtask

  task automatic test_edge_single();
    e_in = 32'hDEAD_BEEF; e_strobe = 1'b1;
    tick(); tick(); tick();
    e_strobe = 1'b0;
    checks++; if (e_count !== 3'd1) begin errors++;
      $display("FAIL edge_held_count got %0d want 1", e_count); end
    checks++; if (e_bus !== 32'hDEAD_BEEF || e_valid !== 1'b1) begin errors++;
      $display("FAIL edge_held_bus got %h valid=%b want deadbeef 1", e_bus, e_valid); end
    tick();
    pop_edge();
    checks++; if (e_count !== 3'd0 || e_bus !== 32'h0 || e_valid !== 1'b0) begin errors++;
      $display("FAIL edge_pop got count=%0d bus=%h valid=%b want 0 0 0", e_count, e_bus, e_valid); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) push_edge(32'(i));
    checks++; if (e_full !== 1'b1 || e_count !== 3'd4 || e_ovf !== 1'b0) begin errors++;
      $display("FAIL fill_full got full=%b count=%0d ovf=%b want 1 4 0", e_full, e_count, e_ovf); end
    push_edge(32'd5);
    checks++; if (e_ovf !== 1'b1 || e_count !== 3'd4) begin errors++;
      $display("FAIL drop_ovf got ovf=%b count=%0d want 1 4", e_ovf, e_count); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (e_bus !== 32'(i)) begin errors++;
        $display("FAIL pop_order_%0d got %h want %h", i, e_bus, 32'(i)); end
      pop_edge();
    end
    checks++; if (e_count !== 3'd0 || e_bus !== 32'h0 || e_ovf !== 1'b1) begin errors++;
      $display("FAIL drained got count=%0d bus=%h ovf=%b want 0 0 1", e_count, e_bus, e_ovf); end
    e_ovfclr = 1'b1; tick(); e_ovfclr = 1'b0;
    checks++; if (e_ovf !== 1'b0) begin errors++;
      $display("FAIL ovf_clr got %b want 0", e_ovf); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_q [4];
    exp_q = '{32'd2, 32'd3, 32'd4, 32'd9};
    // Offset pointers by one so the fill wraps around the end of storage
    push_edge(32'd7); pop_edge();
    for (int i = 1; i <= 4; i++) push_edge(32'(i));
    e_in = 32'd9; e_strobe = 1'b1; e_rd = 1'b1; tick();
    e_strobe = 1'b0; e_rd = 1'b0;
    checks++; if (e_ovf !== 1'b0 || e_count !== 3'd4 || e_full !== 1'b1) begin errors++;
      $display("FAIL full_pushpop got ovf=%b count=%0d full=%b want 0 4 1", e_ovf, e_count, e_full); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (e_bus !== exp_q[i]) begin errors++;
        $display("FAIL wrap_order_%0d got %h want %h", i, e_bus, exp_q[i]); end
      pop_edge();
    end
    checks++; if (e_count !== 3'd0 || e_valid !== 1'b0) begin errors++;
      $display("FAIL wrap_drained got count=%0d valid=%b want 0 0", e_count, e_valid); end
  endtask

  task automatic test_level_mode();
    logic [31:0] words [3];
    words = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    l_strobe = 1'b1;
    for (int i = 0; i < 3; i++) begin l_in = words[i]; tick(); end
    l_strobe = 1'b0;
    checks++; if (l_count !== 3'd3) begin errors++;
      $display("FAIL level_count got %0d want 3", l_count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (l_bus !== words[i]) begin errors++;
        $display("FAIL level_pop_%0d got %h want %h", i, l_bus, words[i]); end
      l_rd = 1'b1; tick(); l_rd = 1'b0;
    end
    l_rd = 1'b1; tick(); l_rd = 1'b0;
    checks++; if (l_count !== 3'd0 || l_bus !== 32'h0 || l_valid !== 1'b0) begin errors++;
      $display("FAIL empty_pop got count=%0d bus=%h valid=%b want 0 0 0", l_count, l_bus, l_valid); end
    // Push and pop together on an empty FIFO: only the push takes effect
    l_in = 32'h1234_5678; l_strobe = 1'b1; l_rd = 1'b1; tick();
    l_strobe = 1'b0; l_rd = 1'b0;
    checks++; if (l_count !== 3'd1 || l_bus !== 32'h1234_5678) begin errors++;
      $display("FAIL empty_pushpop got count=%0d bus=%h want 1 12345678", l_count, l_bus); end
    l_rd = 1'b1; tick(); l_rd = 1'b0;
  endtask

  task automatic test_reset_mid();
    l_strobe = 1'b1;
    for (int i = 0; i < 3; i++) begin l_in = 32'(i + 16); tick(); end
    checks++; if (l_count !== 3'd3) begin errors++;
      $display("FAIL pre_clr_count got %0d want 3", l_count); end
    l_clr = 1'b1; tick();
    l_clr = 1'b0; l_strobe = 1'b0;
    checks++; if (l_count !== 3'd0 || l_bus !== 32'h0 || l_valid !== 1'b0) begin errors++;
      $display("FAIL mid_clr got count=%0d bus=%h valid=%b want 0 0 0", l_count, l_bus, l_valid); end
    // Edge mode: strobe held across reset release gives exactly one push
    e_in = 32'hCAFE_F00D; e_strobe = 1'b1; e_clr = 1'b1; tick();
    e_clr = 1'b0; tick();
    checks++; if (e_count !== 3'd1 || e_bus !== 32'hCAFE_F00D) begin errors++;
      $display("FAIL held_release got count=%0d bus=%h want 1 cafef00d", e_count, e_bus); end
    tick(); tick();
    checks++; if (e_count !== 3'd1) begin errors++;
      $display("FAIL held_no_repeat got count=%0d want 1", e_count); end
    e_strobe = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge_single();
    test_overflow();
    test_full_push_pop();
    test_level_mode();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_input_port_fifo
`default_nettype wire
